uart_tx_buffer: RTL and testbench

Byte FIFO and launch controller sitting directly upstream of the `uart` transmitter. Host logic pushes bytes at any rate up to one per clock; the block drains them one at a time into the transmitter's `tx_data_in`/`start` inputs. It uses the transmitter's `tx_active`/`done_tx` status to pace launches, so frames go out back-to-back with no host involvement.

---
 rtl/uart_tx_buffer.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//
// Byte FIFO plus launch controller placed directly in front of the uart
// transmitter. The host pushes bytes at up to one per clock; the controller
// drains them one at a time into the transmitter's tx_data_in/start inputs and
// paces launches with tx_active/done_tx, so frames go out back-to-back.
//
// Optional feature macro: UART_TXBUF_OVF_EN
//   When defined, adds a sticky overflow flag (ovf) and its clear (ovf_clr).
//   When undefined, pushes into a full FIFO are dropped silently.
//
// Ports:
//   clk         in   system clock, all state on the rising edge
//   rst         in   asynchronous active-high reset
//   wr_en       in   push request
//   wr_data     in   byte to push
//   full        out  FIFO holds DEPTH entries (registered)
//   empty       out  FIFO holds 0 entries (registered)
//   count       out  occupancy 0..DEPTH (registered)
//   tx_data_in  out  byte to the transmitter, held from pop to next pop
//   start       out  launch request, held until tx_active is seen
//   tx_active   in   transmitter is sending a frame
//   done_tx     in   one-cycle pulse at end of frame
//   ovf_clr     in   clears ovf               (UART_TXBUF_OVF_EN only)
//   ovf         out  sticky overflow flag    (UART_TXBUF_OVF_EN only)
// -----------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        tx_data_in,
  output logic              start,
  input  logic              tx_active,
  input  logic              done_tx
`ifdef UART_TXBUF_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              ovf
`endif
);

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_start;
  logic [7:0]          r_tx_data;

  logic                w_push;
  logic                w_pop;
  logic [ADDR_W:0]     w_count_nxt;

  // A push is judged against the registered full flag, so a pop in the same
  // cycle never rescues a push into a full FIFO.
  assign w_push = wr_en & ~r_full;
  // The controller only pops from IDLE, and only when the transmitter is quiet.
  assign w_pop  = (r_state == S_IDLE) & ~r_empty & ~tx_active;

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: the storage array has no reset; entries are only read after being written, and leaving it unreset lets it map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Launch controller. start and tx_data_in are registered outputs of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_start   <= 1'b1;
            r_state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // A frame short enough to finish before tx_active is observed
          // still ends the launch cleanly.
          if (done_tx) begin
            r_start <= 1'b0;
            r_state <= S_GAP;
          end else if (tx_active) begin
            r_start <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (done_tx) r_state <= S_GAP;
        end
        S_GAP: begin
          // One dead cycle lets the transmitter drop tx_active before the
          // next launch decision.
          r_state <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TXBUF_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = wr_en & r_full;

  // Set has priority over clear so a drop coinciding with a clear is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;
`endif

  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign start      = r_start;
  assign tx_data_in = r_tx_data;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffer
//
// Self-checking bench for uart_tx_buffer (DEPTH=16). A small transmitter model
// answers start with a frame of frame_len cycles (tx_active high, then a
// done_tx pulse). Every accepted push places its byte on a scoreboard queue;
// each launch seen by the transmitter model pops and compares the head.
// Honours UART_TXBUF_OVF_EN for the overflow flag checks.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_data_in;
  logic       start;
  logic       tx_active;
  logic       done_tx;
`ifdef UART_TXBUF_OVF_EN
  logic       ovf_clr;
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard and transmitter-model state
  logic [7:0] exp_q[$];
  bit         busy;          // hold tx_active high without a frame
  int         frame_len;
  bit         chk_gap;
  bit         in_frame;
  bit         frame_untracked;
  int         rem;
  int         ncyc;
  int         last_done;
  int         n_frames;
  logic [7:0] cur_byte;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .tx_data_in (tx_data_in),
    .start      (start),
    .tx_active  (tx_active),
    .done_tx    (done_tx)
`ifdef UART_TXBUF_OVF_EN
    ,
    .ovf_clr    (ovf_clr),
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; one rising edge samples the push.
  task automatic push(input logic [7:0] b, input bit acc);
    wr_en   = 1'b1;
    wr_data = b;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(n < 3000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Transmitter model: acts 1 time unit after each negedge.
  initial begin
    tx_active = 1'b0;
    done_tx   = 1'b0;
    in_frame  = 1'b0;
    frame_untracked = 1'b0;
    rem       = 0;
    ncyc      = 0;
    last_done = -1;
    n_frames  = 0;
    cur_byte  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      done_tx = 1'b0;
      if (rst && in_frame) frame_untracked = 1'b1;
      if (in_frame) begin
        if (!frame_untracked) check("tx_data_hold", 32'(tx_data_in), 32'(cur_byte));
        rem--;
        if (rem == 0) begin
          in_frame        = 1'b0;
          frame_untracked = 1'b0;
          tx_active       = 1'b0;
          done_tx         = 1'b1;
          last_done       = ncyc;
        end
      end else if (start && !tx_active) begin
        check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_byte", 32'(tx_data_in), 32'(exp_q.pop_front()));
        // done set at model step n is sampled at the next edge; GAP, then the
        // IDLE pop two edges later, so start is first seen at step n+3.
        if (chk_gap && last_done >= 0) check("gap_after_done", 32'(ncyc - last_done), 32'd3);
        cur_byte  = tx_data_in;
        in_frame  = 1'b1;
        rem       = frame_len;
        tx_active = 1'b1;
        n_frames++;
      end else begin
        tx_active = busy;
      end
      ncyc++;
    end
  end

  // Occupancy invariants, checked every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("count_le_depth", 32'(count <= 5'(DEPTH)), 32'd1);
        check("full_vs_count", 32'(full), 32'(count == 5'(DEPTH)));
        check("empty_vs_count", 32'(empty), 32'(count == 5'd0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    busy      = 1'b0;
    frame_len = 6;
    chk_gap   = 1'b0;
`ifdef UART_TXBUF_OVF_EN
    ovf_clr   = 1'b0;
`endif

    // Reset values
    #1;
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_tx_data", 32'(tx_data_in), 32'h00);
    check("rst_start", 32'(start), 32'd0);
`ifdef UART_TXBUF_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: start and data one cycle after the push
    push(8'hA5, 1'b1);
    check("single_count_after_push", 32'(count), 32'd1);
    check("single_empty_after_push", 32'(empty), 32'd0);
    check("single_start_not_yet", 32'(start), 32'd0);
    @(negedge clk);
    check("single_start", 32'(start), 32'd1);
    check("single_tx_data", 32'(tx_data_in), 32'hA5);
    check("single_count_after_pop", 32'(count), 32'd0);
    check("single_empty_after_pop", 32'(empty), 32'd1);
    wait_drain("single");

    // Burst of three, back-to-back launches
    f0        = n_frames;
    last_done = -1;
    chk_gap   = 1'b1;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    wait_drain("burst");
    chk_gap = 1'b0;
    check("burst_frames", 32'(n_frames - f0), 32'd3);

    // Fill and overflow with the transmitter held busy
    busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(8'(8'hB0 + i), 1'b1);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_empty", 32'(empty), 32'd0);
    check("fill_no_start", 32'(start), 32'd0);
    push(8'hEE, 1'b0);
    check("ovf_push_count", 32'(count), 32'd16);
    check("ovf_push_full", 32'(full), 32'd1);
`ifdef UART_TXBUF_OVF_EN
    check("ovf_set", 32'(ovf), 32'd1);
    wr_en   = 1'b1;
    wr_data = 8'hEF;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_drop_and_clear", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
`endif
    busy = 1'b0;
    wait_drain("fill");

    // Simultaneous push and pop at count=5
    busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 1'b1);
    check("pp_count_before", 32'(count), 32'd5);
    busy = 1'b0;
    push(8'hC5, 1'b1);
    check("pp_count_after", 32'(count), 32'd5);
    wait_drain("pushpop");

    // Pointer wrap: interleaved pushes and drains
    frame_len = 3;
    for (int i = 0; i < 40; i++) begin
      push(8'(i * 7 + 3), 1'b1);
      repeat ($urandom_range(2, 8)) @(negedge clk);
    end
    wait_drain("wrap");

    // Reset mid-frame with four bytes queued
    frame_len = 40;
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 1'b1);
    check("midrst_count_queued", 32'(count), 32'd4);
    check("midrst_in_frame", 32'(in_frame), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_tx_data", 32'(tx_data_in), 32'h00);
    check("midrst_start", 32'(start), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      bit seen_start = 1'b0;
      repeat (60) begin
        @(negedge clk);
        if (start) seen_start = 1'b1;
      end
      check("midrst_no_start", 32'(seen_start), 32'd0);
    end
    push(8'h77, 1'b1);
    wait_drain("after_reset");
    check("final_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
